// File: rtl/qrd_internal_cell_pipe_if.sv
// Beat-level handshake bundle between a QRD internal cell and its neighbours.
// slave is the cell's view; master is the view of whatever drives and consumes it.
interface qrd_internal_cell_pipe_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_CH     = 4
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // input side: rotation from the left cell, sample from the upper cell
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] c_in;
  logic signed [DATA_WIDTH-1:0] s_in;
  logic signed [DATA_WIDTH-1:0] x_in;
  logic [CH_W-1:0]              ch_in;
  logic                         freeze_in;

  // output side: rotation passed right, rotated sample passed down
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] c_out;
  logic signed [DATA_WIDTH-1:0] s_out;
  logic signed [DATA_WIDTH-1:0] x_out;
  logic [CH_W-1:0]              ch_out;
  logic                         sat_out;

  modport master (
    output in_valid, c_in, s_in, x_in, ch_in, freeze_in, out_ready,
    input  in_ready, out_valid, c_out, s_out, x_out, ch_out, sat_out
  );

  modport slave (
    input  in_valid, c_in, s_in, x_in, ch_in, freeze_in, out_ready,
    output in_ready, out_valid, c_out, s_out, x_out, ch_out, sat_out
  );
endinterface

// File: rtl/qrd_internal_cell_pipe.sv
// Givens-rotation internal cell of a systolic QR array, time-multiplexed over
// NUM_CH channels. Two stages: S1 registers the beat, S2 reads r[ch], rotates,
// registers the outputs and writes r[ch] back in the same cycle, so consecutive
// beats on one channel always see the freshest r.
module qrd_internal_cell_pipe #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 14,
  parameter int unsigned NUM_CH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] lambda,
  input  logic                         clear,
  qrd_internal_cell_pipe_if.slave      bus
);
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned SUM_W  = 2 * DATA_WIDTH + 1;

  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  // S1 beat
  logic                         s1_valid;
  logic signed [DATA_WIDTH-1:0] s1_c;
  logic signed [DATA_WIDTH-1:0] s1_s;
  logic signed [DATA_WIDTH-1:0] s1_x;
  logic [CH_W-1:0]              s1_ch;
  logic                         s1_freeze;

  // per-channel r state
  logic signed [DATA_WIDTH-1:0] r_q [NUM_CH];

  logic                         advance;
  logic                         ch_ok;
  logic signed [DATA_WIDTH-1:0] r_cur;
  logic signed [DATA_WIDTH-1:0] rl;
  logic signed [DATA_WIDTH-1:0] x_new;
  logic signed [DATA_WIDTH-1:0] r_new;
  logic                         sat_rl;
  logic                         sat_x;
  logic                         sat_r;
  logic signed [PROD_W-1:0]     p_lr;
  logic signed [PROD_W-1:0]     p_cx;
  logic signed [PROD_W-1:0]     p_srl;
  logic signed [PROD_W-1:0]     p_sx;
  logic signed [PROD_W-1:0]     p_crl;
  logic signed [SUM_W-1:0]      sum_x;
  logic signed [SUM_W-1:0]      sum_r;

  // Clamp a wide signed value to DATA_WIDTH; MSB of the result flags a clamp.
  function automatic logic [DATA_WIDTH:0] sat_fn(input logic signed [SUM_W-1:0] v);
    logic [DATA_WIDTH:0] res;
    if (v > SAT_MAX) begin
      res = {1'b1, SAT_MAX[DATA_WIDTH-1:0]};
    end else if (v < SAT_MIN) begin
      res = {1'b1, SAT_MIN[DATA_WIDTH-1:0]};
    end else begin
      res = {1'b0, v[DATA_WIDTH-1:0]};
    end
    return res;
  endfunction

  // Whole pipe moves together whenever the output register is free or being drained.
  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  // Commit datapath: forget, rotate, and produce the new r for the S1 beat.
  always_comb begin
    ch_ok = (32'(s1_ch) < NUM_CH);
    r_cur = '0;
    if (ch_ok) begin
      r_cur = r_q[s1_ch];
    end

    p_lr = PROD_W'(lambda) * PROD_W'(r_cur);
    {sat_rl, rl} = sat_fn(SUM_W'(p_lr) >>> FRAC_BITS);

    p_cx  = PROD_W'(s1_c) * PROD_W'(s1_x);
    p_srl = PROD_W'(s1_s) * PROD_W'(rl);
    p_sx  = PROD_W'(s1_s) * PROD_W'(s1_x);
    p_crl = PROD_W'(s1_c) * PROD_W'(rl);

    sum_x = SUM_W'(p_cx) - SUM_W'(p_srl);
    sum_r = SUM_W'(p_sx) + SUM_W'(p_crl);

    {sat_x, x_new} = sat_fn(sum_x >>> FRAC_BITS);
    {sat_r, r_new} = sat_fn(sum_r >>> FRAC_BITS);
  end

  // S1: capture the offered beat whenever the pipe advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_c      <= '0;
      s1_s      <= '0;
      s1_x      <= '0;
      s1_ch     <= '0;
      s1_freeze <= 1'b0;
    end else if (advance) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_c      <= bus.c_in;
        s1_s      <= bus.s_in;
        s1_x      <= bus.x_in;
        s1_ch     <= bus.ch_in;
        s1_freeze <= bus.freeze_in;
      end
    end
  end

  // S2: register the committed beat's results onto the output port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_valid <= 1'b0;
      bus.c_out     <= '0;
      bus.s_out     <= '0;
      bus.x_out     <= '0;
      bus.ch_out    <= '0;
      bus.sat_out   <= 1'b0;
    end else if (advance) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.c_out   <= s1_c;
        bus.s_out   <= s1_s;
        bus.x_out   <= x_new;
        bus.ch_out  <= s1_ch;
        bus.sat_out <= sat_rl | sat_x | sat_r;
      end
    end
  end

  // r state: clear wins over a same-cycle commit; frozen or out-of-range beats never write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '{default: '0};
    end else if (clear) begin
      r_q <= '{default: '0};
    end else if (advance && s1_valid && !s1_freeze && ch_ok) begin
      r_q[s1_ch] <= r_new;
    end
  end
endmodule

// File: tb/tb_qrd_internal_cell_pipe.sv
// Directed bench for qrd_internal_cell_pipe. NUM_CH=3 so channel index 3 is a
// legal port value but out of range. r values are observed through frozen
// probe beats (c=0, s=-1.0, x=0, lambda=1.0) whose x_out equals r[ch].
module tb_qrd_internal_cell_pipe;
  localparam int unsigned DW  = 16;
  localparam int unsigned FB  = 14;
  localparam int unsigned NCH = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] lambda;
  logic                 clear;

  always #5 clk = ~clk;

  qrd_internal_cell_pipe_if #(.DATA_WIDTH(DW), .NUM_CH(NCH)) bus ();

  qrd_internal_cell_pipe #(
    .DATA_WIDTH(DW),
    .FRAC_BITS (FB),
    .NUM_CH    (NCH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .lambda(lambda),
    .clear (clear),
    .bus   (bus)
  );

  typedef struct packed {
    logic signed [15:0] x;
    logic               sat;
    logic [1:0]         ch;
    logic signed [15:0] c;
    logic signed [15:0] s;
  } beat_t;

  beat_t obs_q[$];
  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    lat;

  // capture every output transfer (the transfer happens at the next rising edge)
  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      obs_q.push_back({bus.x_out, bus.sat_out, bus.ch_out, bus.c_out, bus.s_out});
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", tag, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one beat and return just after the edge that accepted it.
  task automatic send(input logic signed [15:0] c, input logic signed [15:0] s,
                      input logic signed [15:0] x, input logic [1:0] ch, input logic frz,
                      input logic signed [15:0] ex, input logic esat);
    logic acc;
    int   waits;
    acc   = 1'b0;
    waits = 0;
    bus.c_in      = c;
    bus.s_in      = s;
    bus.x_in      = x;
    bus.ch_in     = ch;
    bus.freeze_in = frz;
    bus.in_valid  = 1'b1;
    exp_q.push_back({ex, esat, ch, c, s});
    while (!acc && waits < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      waits++;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic probe(input logic [1:0] ch, input logic signed [15:0] r_exp);
    send(16'sd0, -16'sd16384, 16'sd0, ch, 1'b1, r_exp, 1'b0);
  endtask

  // Wait for all expected outputs, then compare them in order.
  task automatic drain(input string tag);
    int w;
    w = 0;
    bus.in_valid = 1'b0;
    while (obs_q.size() < exp_q.size() && w < 100) begin
      tick(1);
      w++;
    end
    tick(3);
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s_x%0d", tag, i),   32'(obs_q[i].x),   32'(exp_q[i].x));
      check($sformatf("%s_sat%0d", tag, i), 32'(obs_q[i].sat), 32'(exp_q[i].sat));
      check($sformatf("%s_ch%0d", tag, i),  32'(obs_q[i].ch),  32'(exp_q[i].ch));
      check($sformatf("%s_c%0d", tag, i),   32'(obs_q[i].c),   32'(exp_q[i].c));
      check($sformatf("%s_s%0d", tag, i),   32'(obs_q[i].s),   32'(exp_q[i].s));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b0;
    lambda        = 16'sd16384;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.c_in      = '0;
    bus.s_in      = '0;
    bus.x_in      = '0;
    bus.ch_in     = '0;
    bus.freeze_in = 1'b0;
    bus.out_ready = 1'b1;
    tick(3);

    // reset state
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_x_out",     32'(bus.x_out),     32'd0);
    check("rst_c_out",     32'(bus.c_out),     32'd0);
    check("rst_ch_out",    32'(bus.ch_out),    32'd0);
    check("rst_sat_out",   32'(bus.sat_out),   32'd0);
    rst = 1'b1;
    tick(1);

    // first beat latency, then back-to-back ch0 sequence
    bus.c_in = 16'sd16384; bus.s_in = 16'sd0; bus.x_in = 16'sd8192;
    bus.ch_in = 2'd0; bus.freeze_in = 1'b0; bus.in_valid = 1'b1;
    exp_q.push_back({16'sd8192, 1'b0, 2'd0, 16'sd16384, 16'sd0});
    tick(1);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick(1);
      lat++;
    end
    check("latency", 32'(lat), 32'd2);
    send(16'sd0,     16'sd16384, 16'sd4096, 2'd0, 1'b0, 16'sd0,   1'b0);
    send(16'sd16384, 16'sd0,     16'sd100,  2'd0, 1'b0, 16'sd100, 1'b0);
    probe(2'd0, 16'sd4096);
    drain("basic");

    // positive saturation of r_new
    send(16'sd0,     16'sd16384, 16'sd16384, 2'd1, 1'b0, 16'sd0, 1'b0);
    send(16'sd16384, 16'sd16384, 16'sd16384, 2'd1, 1'b0, 16'sd0, 1'b1);
    probe(2'd1, 16'sd32767);
    drain("sat");

    // floor truncation and x_out clamping on frozen ch0 beats (r0=4096)
    send(16'sd8192,   16'sd0,     -16'sd3,     2'd0, 1'b1, -16'sd2,     1'b0);
    send(-16'sd16384, 16'sd0,     -16'sd32768, 2'd0, 1'b1, 16'sd32767,  1'b1);
    send(-16'sd16384, 16'sd16384, 16'sd32767,  2'd0, 1'b1, -16'sd32768, 1'b1);
    probe(2'd0, 16'sd4096);
    drain("trunc");

    // forgetting factor and freeze
    send(16'sd0, 16'sd16384, 16'sd16384, 2'd2, 1'b0, 16'sd0, 1'b0);
    drain("forget_pre");
    lambda = 16'sd8192;
    send(16'sd16384, 16'sd0, 16'sd0, 2'd2, 1'b0, 16'sd0, 1'b0);
    send(16'sd16384, 16'sd0, 16'sd0, 2'd2, 1'b1, 16'sd0, 1'b0);
    drain("forget_run");
    lambda = 16'sd16384;
    probe(2'd2, 16'sd8192);
    drain("forget");

    // out-of-range channel: r treated as 0 and never written
    send(16'sd0, 16'sd16384,  16'sd16384, 2'd3, 1'b0, 16'sd0, 1'b0);
    send(16'sd0, -16'sd16384, 16'sd0,     2'd3, 1'b0, 16'sd0, 1'b0);
    probe(2'd0, 16'sd4096);
    drain("oor");

    // idle clear pulse
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    probe(2'd0, 16'sd0);
    probe(2'd1, 16'sd0);
    probe(2'd2, 16'sd0);
    drain("clear");

    // backpressure: two accepted, third held off, output stable
    bus.out_ready = 1'b0;
    send(16'sd16384, 16'sd16384, 16'sd4096, 2'd0, 1'b0, 16'sd4096,  1'b0);
    send(16'sd0,     16'sd16384, 16'sd1000, 2'd0, 1'b0, -16'sd4096, 1'b0);
    bus.c_in = 16'sd16384; bus.s_in = 16'sd0; bus.x_in = 16'sd50;
    bus.ch_in = 2'd0; bus.freeze_in = 1'b0; bus.in_valid = 1'b1;
    tick(3);
    check("bp_in_ready",  32'(bus.in_ready),  32'd0);
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    check("bp_x_hold",    32'(bus.x_out),     32'd4096);
    check("bp_no_xfer",   32'(obs_q.size()),  32'd0);
    bus.out_ready = 1'b1;
    send(16'sd16384, 16'sd0, 16'sd50, 2'd0, 1'b0, 16'sd50, 1'b0);
    probe(2'd0, 16'sd1000);
    drain("bp");

    // interleaved channels keep independent r
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    send(16'sd0,     16'sd16384, 16'sd2000, 2'd0, 1'b0, 16'sd0,     1'b0);
    send(16'sd0,     16'sd16384, 16'sd3000, 2'd1, 1'b0, 16'sd0,     1'b0);
    send(16'sd16384, 16'sd0,     16'sd10,   2'd0, 1'b0, 16'sd10,    1'b0);
    send(16'sd0,     16'sd16384, 16'sd7,    2'd1, 1'b0, -16'sd3000, 1'b0);
    probe(2'd0, 16'sd2000);
    probe(2'd1, 16'sd7);
    drain("ilv");

    // clear in the commit cycle: beat sees old r, write is discarded
    send(16'sd0, 16'sd16384, 16'sd500, 2'd1, 1'b0, -16'sd7, 1'b0);
    bus.in_valid = 1'b0;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    probe(2'd1, 16'sd0);
    probe(2'd0, 16'sd0);
    drain("clr_commit");

    // asynchronous reset with both stages full
    bus.out_ready = 1'b0;
    send(16'sd16384, 16'sd16384, 16'sd1234, 2'd0, 1'b0, 16'sd0, 1'b0);
    send(16'sd0,     16'sd16384, 16'sd1,    2'd0, 1'b0, 16'sd0, 1'b0);
    bus.in_valid = 1'b0;
    check("full_out_valid", 32'(bus.out_valid), 32'd1);
    check("full_x_out",     32'(bus.x_out),     32'd1234);
    #2;
    rst = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_x_out",     32'(bus.x_out),     32'd0);
    check("arst_c_out",     32'(bus.c_out),     32'd0);
    check("arst_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    obs_q.delete();
    exp_q.delete();
    bus.out_ready = 1'b1;
    bus.c_in = 16'sd0; bus.s_in = -16'sd16384; bus.x_in = 16'sd0;
    bus.ch_in = 2'd0; bus.freeze_in = 1'b1; bus.in_valid = 1'b1;
    exp_q.push_back({16'sd0, 1'b0, 2'd0, 16'sd0, -16'sd16384});
    tick(1);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick(1);
      lat++;
    end
    check("post_rst_latency", 32'(lat), 32'd2);
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/qrd_internal_cell_pipe.md
QRD_INTERNAL_CELL_PIPE -- requirements
Module: qrd_internal_cell_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 16, signed two's-complement width of all data ports and of the stored r values.
REQ-002 Parameter FRAC_BITS, default 14, number of fractional bits (Q format; 1.0 = 2^FRAC_BITS).
REQ-003 Parameter NUM_CH, default 4, number of independent time-multiplexed channels, each holding its own r value; CH_W = max(1, clog2(NUM_CH)).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  input beat valid.
REQ-008 in_ready  out  1  block accepts the input beat this cycle.
REQ-009 c_in, s_in  in  DATA_WIDTH each  Givens cosine/sine from the left cell.
REQ-010 x_in  in  DATA_WIDTH  sample from the upper cell.
REQ-011 ch_in  in  CH_W  channel index of the beat.
REQ-012 freeze_in  in  1  per-beat flag: compute x_out but do not update r[ch].
REQ-013 lambda  in  DATA_WIDTH  forgetting factor (Q format, quasi-static), sampled at commit.
REQ-014 clear  in  1  synchronous pulse zeroing all r values.
REQ-015 out_valid  out  1; out_ready  in  1  output handshake.
REQ-016 c_out, s_out  out  DATA_WIDTH  c_in/s_in of the beat, aligned with x_out.
REQ-017 x_out  out  DATA_WIDTH  rotated sample to the lower cell.
REQ-018 ch_out  out  CH_W; sat_out  out  1  channel of the beat, and saturation-occurred flag for the beat.

Function
REQ-019 Two-stage pipeline: S1 registers the input beat; S2 (commit) computes results, registers outputs and writes r[ch]; latency 2 cycles from accepted beat to out_valid with no stall.
REQ-020 advance = !out_valid | out_ready; in_ready SHALL equal advance; a beat transfers on in_valid & in_ready, an output on out_valid & out_ready.
REQ-021 On advance: the S1 beat (if any) moves to S2/outputs and out_valid takes S1 valid; S1 loads the input beat and its valid takes in_valid.
REQ-022 When advance is 0, S1, all outputs and all r values SHALL hold unchanged (no loss, no duplication).
REQ-023 Commit arithmetic on beat (c, s, x, ch): rl = sat((lambda*r[ch]) >>> FRAC_BITS); x_out = sat((c*x - s*rl) >>> FRAC_BITS); r_new = sat((s*x + c*rl) >>> FRAC_BITS).
REQ-024 Products full 2*DATA_WIDTH signed, sums 2*DATA_WIDTH+1 bits, arithmetic right shift (truncation toward minus infinity), no rounding.
REQ-025 sat() clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; sat_out = 1 if any of the three sat() operations clamped for that beat.
REQ-026 r[ch] <= r_new at commit unless freeze of the beat is 1; other channels unaffected.
REQ-027 Back-to-back beats on one channel SHALL see the r written by the previous commit (commit reads and writes r in the same stage; no hazard).
REQ-028 clear = 1 zeroes all r at the next edge, overriding any same-cycle commit write; a beat committing in that cycle uses the pre-clear r for x_out.
REQ-029 ch_in >= NUM_CH: beat passes through with x_out computed using r = 0, no r write.

Reset
REQ-030 rst low SHALL immediately force in S1 valid = 0, out_valid = 0, all r = 0, c_out = s_out = x_out = 0, ch_out = 0, sat_out = 0, regardless of clock, including mid-operation.
REQ-031 After rst deasserts, in_ready = 1 and the first accepted beat produces out_valid exactly 2 cycles later.

Verification (DATA_WIDTH=16, FRAC_BITS=14, lambda=16384, out_ready=1 unless stated)
REQ-032 ch0: (c=16384,s=0,x=8192) -> x_out=8192, r0 stays 0; then (c=0,s=16384,x=4096) -> x_out=0, r0=4096; then (c=16384,s=0,x=100) -> x_out=100, r0=4096.
REQ-033 Saturation: ch1 (c=0,s=16384,x=16384) -> r1=16384; then (c=16384,s=16384,x=16384) -> x_out=0, r1=32767, sat_out=1.
REQ-034 Forgetting: r2=16384, lambda=8192, beat (c=16384,s=0,x=0) -> r2=8192, x_out=0; same beat with freeze_in=1 -> r2 unchanged.
REQ-035 Backpressure: out_ready=0, three beats offered -> two accepted, in_ready=0, outputs stable; out_ready=1 -> beats emerge in order, nothing lost, r updated once per beat.
REQ-036 Interleaved ch0/ch1 alternate beats keep independent r values; clear pulse with a commit in the same cycle -> all r=0 next cycle, that beat's x_out uses old r.
REQ-037 rst pulsed low with both stages full -> out_valid=0 and all r=0 immediately; first post-reset beat appears after exactly 2 cycles.
